sd_zbridge: RTL and testbench
=============================

Name: sd_zbridge

Overview:
Upstream bus bridge between the TV80 core's raw memory bus and the sd_zmem scoreboard-backed memory port.
- Decodes a parameterised address window and launches one memory-port cycle per CPU access.
- Stretches the CPU cycle with wait_n until the memory port acks, then holds read data stable until the CPU releases its strobes.
- Accesses outside the window complete immediately with 8'hFF.
- A timeout counter prevents a hung memory port from freezing the CPU.

Parameters:
z_asz, 16, CPU and memory-port address width
mem_base, 0, first CPU address mapped to memory-port address 0
mem_size, 8192, number of bytes in window; hit when mem_base <= cpu_addr < mem_base+mem_size
timeout, 255, max cycles spent in BUSY before abort (1..65535, 16-bit counter)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cpu_mreq_n  in  1  TV80 memory request, active low
cpu_rd_n  in  1  TV80 read strobe, active low
cpu_wr_n  in  1  TV80 write strobe, active low
cpu_addr  in  z_asz  TV80 address
cpu_dout  in  8  TV80 write data
cpu_din  out  8  read data to TV80 (registered)
cpu_wait_n  out  1  wait to TV80, active low
err  out  1  sticky timeout flag
mreq_n  out  1  memory-port request (registered)
cs_n  out  1  memory-port chip select (registered)
rd_n  out  1  memory-port read strobe (registered)
wr_n  out  1  memory-port write strobe (registered)
addr  out  z_asz  memory-port address = cpu_addr - mem_base (registered)
wr_data  out  8  memory-port write data (registered)
ack  in  1  memory-port completion, single-cycle pulse
rd_data  in  8  memory-port read data, valid with ack

Behaviour:
Reset (reset_n low, async):
- State IDLE; cpu_din=8'hFF; err=0.
- mreq_n, cs_n, rd_n, wr_n all 1; addr=0; wr_data=0.
- Counter=0. cpu_wait_n=1 by decode.

Start condition: start = !cpu_mreq_n & (!cpu_rd_n | !cpu_wr_n).
- hit compare is computed in z_asz+1 bits so that mem_base+mem_size at 2^z_asz does not wrap.
- Address subtraction is truncated to z_asz bits.

States:
- IDLE
  - start & hit: register addr/wr_data; drive mreq_n=0, cs_n=0; wr_n=cpu_wr_n; rd_n = cpu_wr_n ? cpu_rd_n : 1. Clear counter; go BUSY.
  - start & !hit: cpu_din<=8'hFF; go DONE. No memory-port activity.
- BUSY
  - Hold all memory-port outputs; counter increments each cycle.
  - ack=1: cpu_din<=rd_data if read (cpu_din unchanged on write); deassert mreq_n/cs_n/rd_n/wr_n; go DONE.
  - counter==timeout-1 without ack: err<=1; cpu_din<=8'hFF; deassert strobes; go DONE.
  - If ack and timeout coincide, ack wins and err is not set.
- DONE
  - Outputs idle; wait for cpu_mreq_n=1 or (cpu_rd_n & cpu_wr_n); then go IDLE.
  - A new start cannot be accepted in the same cycle it is seen released.

Wait and latency:
- cpu_wait_n is combinational: 0 when state==BUSY, or when state==IDLE & start & hit; else 1.
- Memory-port request is visible one cycle after start; cpu_wait_n rises the cycle after ack.
- Miss: cpu_wait_n never drops; data is valid the next cycle.

Boundary and illegal cases:
- ack outside BUSY is ignored.
- rd_n and wr_n both low: treated as write.
- Strobe release while in BUSY: the cycle still completes; DONE exits immediately after.
- err clears only on reset.
- Back-to-back CPU accesses require at least one idle cycle between them.

Decomposition:
- Shared package sd_zbridge_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - miss/abort data constant ZB_FILL=8'hFF
  - counter width constant 16
- One natural sub-module, sd_zdecode (hit compare plus offset subtraction, combinational, parameterised by z_asz/mem_base/mem_size). It is reused for future I/O decode.
- The FSM stays in sd_zbridge.

Test Plan:
- Mapped write: mem_base=16'h8000; CPU writes 8'h5A to 16'h8010; memory-port ack 3 cycles after cs_n falls -> addr=16'h0010, wr_data=8'h5A, wr_n=0, rd_n=1; cpu_wait_n low 4 cycles total; strobes high the cycle after ack.
- Mapped read: read 16'h8020, ack with rd_data=8'hC3 -> cpu_din=8'hC3 the cycle after ack; cpu_din held until the next completed access.
- Unmapped read: read 16'h7FFF, then 16'hA000 with mem_size=8192 -> no cs_n activity; cpu_wait_n stays 1; cpu_din=8'hFF.
- Timeout: timeout=4, never ack -> cs_n rises after 4 BUSY cycles; err=1 and stays 1; cpu_din=8'hFF; a late ack pulse causes no change.
- Ack on final cycle: ack coincident with timeout expiry -> err stays 0; cpu_din=rd_data.
- Reset mid-cycle: assert reset_n=0 while BUSY -> all memory strobes 1 and cpu_wait_n=1 immediately, err=0; after release, the next read completes normally.

Source files
------------

// File: rtl/sd_zbridge_pkg.sv
// Shared definitions for the TV80-to-sd_zmem bridge: state encoding and constants.
package sd_zbridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } zb_state_e;

    localparam logic [7:0] ZB_FILL  = 8'hFF;
    localparam int         ZB_CNT_W = 16;

endpackage

// File: rtl/sd_zbridge_zdecode.sv
// Address window decode: hit flag plus window-relative offset, purely combinational.
import sd_zbridge_pkg::*;

module sd_zdecode #(
    parameter int z_asz    = 16,
    parameter int mem_base = 0,
    parameter int mem_size = 8192
) (
    input  logic [z_asz-1:0] addr,
    output logic             hit,
    output logic [z_asz-1:0] offset
);

    localparam logic [z_asz:0] BASE_W = (z_asz+1)'(mem_base);
    localparam logic [z_asz:0] SIZE_W = (z_asz+1)'(mem_size);

    logic [z_asz:0] rel;

    // One extra bit: an address below the base wraps to a value above any legal size,
    // so a single unsigned compare covers both window edges without overflow at 2^z_asz.
    assign rel    = {1'b0, addr} - BASE_W;
    assign hit    = (rel < SIZE_W);
    assign offset = rel[z_asz-1:0];

endmodule

// File: rtl/sd_zbridge.sv
// TV80 memory bus to sd_zmem port bridge: window decode, wait stretching and timeout abort.
import sd_zbridge_pkg::*;

module sd_zbridge #(
    parameter int z_asz    = 16,
    parameter int mem_base = 0,
    parameter int mem_size = 8192,
    parameter int timeout  = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_mreq_n,
    input  logic             cpu_rd_n,
    input  logic             cpu_wr_n,
    input  logic [z_asz-1:0] cpu_addr,
    input  logic [7:0]       cpu_dout,
    output logic [7:0]       cpu_din,
    output logic             cpu_wait_n,
    output logic             err,
    output logic             mreq_n,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic [z_asz-1:0] addr,
    output logic [7:0]       wr_data,
    input  logic             ack,
    input  logic [7:0]       rd_data
);

    localparam logic [ZB_CNT_W-1:0] TO_LAST = ZB_CNT_W'(timeout - 1);

    logic             hit;
    logic [z_asz-1:0] offset;
    logic             start;

    sd_zdecode #(
        .z_asz   (z_asz),
        .mem_base(mem_base),
        .mem_size(mem_size)
    ) u_decode (
        .addr  (cpu_addr),
        .hit   (hit),
        .offset(offset)
    );

    assign start = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);

    zb_state_e            state_q, state_d;
    logic [ZB_CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]           din_q, din_d;
    logic                 err_q, err_d;
    logic                 mreq_n_q, mreq_n_d;
    logic                 cs_n_q, cs_n_d;
    logic                 rd_n_q, rd_n_d;
    logic                 wr_n_q, wr_n_d;
    logic [z_asz-1:0]     addr_q, addr_d;
    logic [7:0]           wr_data_q, wr_data_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        err_d     = err_q;
        mreq_n_d  = mreq_n_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start && hit) begin
                    addr_d    = offset;
                    wr_data_d = cpu_dout;
                    mreq_n_d  = 1'b0;
                    cs_n_d    = 1'b0;
                    wr_n_d    = cpu_wr_n;
                    // Both strobes low is resolved as a write.
                    rd_n_d    = cpu_wr_n ? cpu_rd_n : 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end else if (start) begin
                    din_d   = ZB_FILL;
                    state_d = ST_DONE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (ack) begin
                    if (!rd_n_q) din_d = rd_data;
                    mreq_n_d = 1'b1;
                    cs_n_d   = 1'b1;
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    din_d    = ZB_FILL;
                    mreq_n_d = 1'b1;
                    cs_n_d   = 1'b1;
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cpu_mreq_n || (cpu_rd_n && cpu_wr_n)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            din_q     <= ZB_FILL;
            err_q     <= 1'b0;
            mreq_n_q  <= 1'b1;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            err_q     <= err_d;
            mreq_n_q  <= mreq_n_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Wait drops in the very cycle a mapped access is decoded, before BUSY is entered.
    assign cpu_wait_n = !((state_q == ST_BUSY) || ((state_q == ST_IDLE) && start && hit));
    assign cpu_din    = din_q;
    assign err        = err_q;
    assign mreq_n     = mreq_n_q;
    assign cs_n       = cs_n_q;
    assign rd_n       = rd_n_q;
    assign wr_n       = wr_n_q;
    assign addr       = addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_sd_zbridge.sv
// Directed bench for sd_zbridge: window 8000..9FFF, timeout of 4 BUSY cycles.
module tb_sd_zbridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_wait_n, err;
    logic        mreq_n, cs_n, rd_n, wr_n;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        ack;
    logic [7:0]  rd_data;

    always #5 clk = ~clk;

    sd_zbridge #(
        .z_asz   (16),
        .mem_base(32'h8000),
        .mem_size(8192),
        .timeout (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_mreq_n(cpu_mreq_n),
        .cpu_rd_n  (cpu_rd_n),
        .cpu_wr_n  (cpu_wr_n),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_wait_n(cpu_wait_n),
        .err       (err),
        .mreq_n    (mreq_n),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .addr      (addr),
        .wr_data   (wr_data),
        .ack       (ack),
        .rd_data   (rd_data)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    logic [7:0] din_m;
    logic       err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cpu_idle();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
    endtask

    // ack_cyc: BUSY cycle (1-based) in which the memory port acks; 0 means never.
    task automatic access(input bit rd_low, input bit wr_low, input logic [15:0] a,
                          input logic [7:0] wd, input int ack_cyc, input logic [7:0] rdat,
                          input bit mapped);
        int         busy = 0;
        int         wlow = 0;
        int         exp_busy;
        bit         acked;
        bit         cs_seen = 0;
        bit         done = 0;
        logic [8:0] e;
        acked = (ack_cyc >= 1) && (ack_cyc <= 4);
        if (!mapped) din_m = 8'hFF;
        else if (acked) begin
            if (!wr_low) din_m = rdat;
        end else begin
            din_m = 8'hFF;
            err_m = 1'b1;
        end
        exp_q.push_back({err_m, din_m});
        exp_busy = !mapped ? 0 : (acked ? ack_cyc : 4);

        @(negedge clk);
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = !rd_low;
        cpu_wr_n   = !wr_low;
        cpu_addr   = a;
        cpu_dout   = wd;
        #1;
        chk("wait_n_at_start", {31'd0, cpu_wait_n}, {31'd0, !mapped});
        if (!cpu_wait_n) wlow++;
        for (int c = 0; c < 30 && !done; c++) begin
            @(posedge clk);
            #1;
            ack = 1'b0;
            if (!cs_n) begin
                cs_seen = 1'b1;
                busy++;
                if (busy == 1) begin
                    chk("mem_addr", {16'd0, addr}, {16'd0, a - 16'h8000});
                    chk("mem_mreq_n", {31'd0, mreq_n}, 32'd0);
                    chk("mem_wr_n", {31'd0, wr_n}, {31'd0, !wr_low});
                    chk("mem_rd_n", {31'd0, rd_n}, {31'd0, wr_low});
                    if (wr_low) chk("mem_wr_data", {24'd0, wr_data}, {24'd0, wd});
                end
                if (busy == ack_cyc) begin
                    ack     = 1'b1;
                    rd_data = rdat;
                end
            end
            if (!cpu_wait_n) wlow++;
            else done = 1'b1;
        end
        chk("done_in_budget", {31'd0, done}, 32'd1);
        chk("busy_cycles", busy, exp_busy);
        chk("wait_low_cycles", wlow, mapped ? exp_busy + 1 : 0);
        chk("cs_activity", {31'd0, cs_seen}, {31'd0, mapped});
        e = exp_q.pop_front();
        chk("cpu_din", {24'd0, cpu_din}, {24'd0, e[7:0]});
        chk("err", {31'd0, err}, {31'd0, e[8]});
        chk("strobes_idle", {28'd0, mreq_n, cs_n, rd_n, wr_n}, 32'hF);
        @(negedge clk);
        cpu_idle();
        @(posedge clk);
        #1;
        chk("din_held", {24'd0, cpu_din}, {24'd0, e[7:0]});
    endtask

    initial begin
        reset_n  = 1'b0;
        cpu_idle();
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        ack      = 1'b0;
        rd_data  = 8'h00;
        din_m    = 8'hFF;
        err_m    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din", {24'd0, cpu_din}, 32'hFF);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_strobes", {28'd0, mreq_n, cs_n, rd_n, wr_n}, 32'hF);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        access(1'b0, 1'b1, 16'h8010, 8'h5A, 3, 8'h00, 1'b1);
        access(1'b1, 1'b0, 16'h8020, 8'h00, 2, 8'hC3, 1'b1);
        access(1'b0, 1'b1, 16'h8030, 8'h77, 1, 8'h99, 1'b1);
        access(1'b1, 1'b0, 16'h7FFF, 8'h00, 1, 8'h12, 1'b0);
        access(1'b1, 1'b0, 16'hA000, 8'h00, 1, 8'h34, 1'b0);
        access(1'b1, 1'b1, 16'h8040, 8'hE1, 2, 8'h55, 1'b1);
        access(1'b1, 1'b0, 16'h8000, 8'h00, 4, 8'hA7, 1'b1);
        access(1'b1, 1'b0, 16'h9FFF, 8'h00, 0, 8'h00, 1'b1);

        // Late ack after the abort must be ignored.
        @(negedge clk);
        ack     = 1'b1;
        rd_data = 8'h11;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("late_ack_din", {24'd0, cpu_din}, {24'd0, din_m});
        chk("late_ack_err", {31'd0, err}, {31'd0, err_m});
        chk("late_ack_cs_n", {31'd0, cs_n}, 32'd1);

        // Reset while BUSY, CPU releasing its strobes at the same moment.
        @(negedge clk);
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        cpu_addr   = 16'h8020;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_reset", {31'd0, cs_n}, 32'd0);
        reset_n = 1'b0;
        cpu_idle();
        din_m = 8'hFF;
        err_m = 1'b0;
        #1;
        chk("midrst_strobes", {28'd0, mreq_n, cs_n, rd_n, wr_n}, 32'hF);
        chk("midrst_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_din", {24'd0, cpu_din}, 32'hFF);
        @(negedge clk);
        reset_n = 1'b1;

        access(1'b1, 1'b0, 16'h9FFF, 8'h00, 2, 8'h3C, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
